multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be clk and rst_n.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- Inst  in  3  instruction class, IR[29:27]
- OPC  in  3  ALU opcode, IR[22:20]
- I  in  1  immediate operand, IR[23]
- L_tr  in  1  1=load, 0=store, IR[20]
- L_br  in  1  branch-with-link, IR[26]
- D  in  1  condition passed
- E  in  1  compare/test class (no register writeback)
- PCWrite, IorD, MemWrite, MemRead, IRWrite, RR2sel, WRsel, RegWrite, ALUsrcA, PCsrc, flag_write, ALUop  out  1 each  datapath controls
- ALUsrcB  out  2  00=1, 01=B, 10=Op2_offset, 11=offset
- WDsel  out  2  00=MDR, 01=PC, 10=ALUout
- ALUctrl  out  3  ALU operation
- retire  out  1  one-cycle pulse on instruction completion

Function
REQ-003 Mux semantics SHALL be as follows:
- IorD: 0=PC, 1=ALUout
- RR2sel: 0=Rd, 1=Rm
- WRsel: 0=Rd, 1=R15
- ALUsrcA: 0=PC, 1=A
- PCsrc: 0=ALU result, 1=ALUout
REQ-004 Inst encodings SHALL be 000=data-processing (DP), 010=memory transfer (MEM), 101=branch (BR); every other code is illegal.
REQ-005 ALUctrl SHALL equal OPC when ALUop=1, and SHALL equal ALU_ADD=3'b000 otherwise.
REQ-006 Every output not listed for a state SHALL be 0.
REQ-007 The FSM states, their outputs and their transitions SHALL be:
- INIT: all outputs 0 -> FETCH.
- FETCH: MemRead=1, IRWrite=1, PCWrite=1 (PC <= PC+1); ALU adds PC+1 -> DECODE.
- DECODE: RR2sel=(Inst!=MEM), ALUsrcB=11, ALU adds PC+offset into ALUout. Next state: D=0 or Inst illegal -> FETCH; DP -> DP_EXEC; MEM -> MEM_ADDR; BR -> BRANCH.
- DP_EXEC: ALUsrcA=1, ALUsrcB=(I?10:01), ALUop=1, flag_write=1. E=1 -> FETCH; else -> DP_WB.
- DP_WB: RegWrite=1, WDsel=10 -> FETCH.
- MEM_ADDR: ALUsrcA=1, ALUsrcB=10, ALUctrl=ADD. L_tr=1 -> MEM_READ; else -> MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1 -> MEM_WB.
- MEM_WB: RegWrite=1, WDsel=00 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1 -> FETCH.
- BRANCH: PCWrite=1, PCsrc=1, RegWrite=L_br, WRsel=1, WDsel=01 -> FETCH.
REQ-008 retire SHALL be 1 in every state whose next state is FETCH, except INIT.
REQ-009 Instruction latencies in cycles SHALL be:
- skipped (D=0 or illegal): 2
- DP with E=1: 3
- DP: 4
- BR: 3
- store: 4
- load: 5
REQ-010 Outputs SHALL be decoded from the current state plus the inputs I, L_tr, L_br, E, D, Inst and OPC; those inputs are IR-derived and stable from DECODE onward.
REQ-011 MemRead and MemWrite SHALL never both be 1, and PCWrite and RegWrite SHALL both be 1 only in BRANCH.

Reset
REQ-012 rst_n=0 SHALL force state INIT asynchronously, with all outputs 0 (including retire) while rst_n is held low.
REQ-013 Reset asserted mid-instruction SHALL abandon the instruction with no further write-enable pulses.
REQ-014 The first FETCH SHALL occur on the second rising edge after rst_n deasserts.

Structure
REQ-015 A shared package SHALL hold the state enum, the Inst class codes, ALU_ADD, and the ALUsrcB/WDsel select constants.
REQ-016 The design SHALL consist of one state register plus a next-state block, and one combinational sub-module, mc_output_decoder, that maps state and inputs to outputs.

Verification
REQ-017 Bench scenario, reset: hold rst_n=0 3 cycles, then release -> all outputs 0, INIT for one cycle, then FETCH with MemRead=IRWrite=PCWrite=1.
REQ-018 Bench scenario, DP register op: Inst=000, D=1, E=0, I=0, OPC=010 -> states DECODE, DP_EXEC, DP_WB; ALUctrl=010 and flag_write=1 in DP_EXEC; RegWrite=1 with WDsel=10 in DP_WB; retire in DP_WB.
REQ-019 Bench scenario, compare: Inst=000, E=1, I=1 -> ALUsrcB=10 in DP_EXEC, no RegWrite, back to FETCH after 3 cycles.
REQ-020 Bench scenario, load then store:
- L_tr=1 -> MEM_ADDR, MEM_READ (IorD=1, MemRead=1), MEM_WB (WDsel=00), 5 cycles total.
- L_tr=0 -> MemWrite=1 for exactly one cycle, 4 cycles total.
REQ-021 Bench scenario, branch: Inst=101, L_br=1 -> BRANCH with PCWrite=PCsrc=RegWrite=WRsel=1 and WDsel=01; with L_br=0, RegWrite=0.
REQ-022 Bench scenarios, skip and abort:
- D=0 or Inst=111 -> DECODE goes to FETCH, retire=1, no write enables.
- rst_n pulsed low during MEM_READ -> outputs 0 immediately, no MEM_WB.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle datapath controller.
package multicycle_controller_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned INST_W  = 3;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_DP_EXEC   = 4'd3,
    S_DP_WB     = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9
  } state_t;

  localparam logic [INST_W-1:0] INST_DP  = 3'b000;
  localparam logic [INST_W-1:0] INST_MEM = 3'b010;
  localparam logic [INST_W-1:0] INST_BR  = 3'b101;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;

  localparam logic [SEL_W-1:0] ALUSRCB_ONE    = 2'b00;
  localparam logic [SEL_W-1:0] ALUSRCB_B      = 2'b01;
  localparam logic [SEL_W-1:0] ALUSRCB_OP2    = 2'b10;
  localparam logic [SEL_W-1:0] ALUSRCB_OFFSET = 2'b11;

  localparam logic [SEL_W-1:0] WDSEL_MDR    = 2'b00;
  localparam logic [SEL_W-1:0] WDSEL_PC     = 2'b01;
  localparam logic [SEL_W-1:0] WDSEL_ALUOUT = 2'b10;

  // Datapath control bundle produced by the output decoder.
  typedef struct packed {
    logic             pc_write;
    logic             iord;
    logic             mem_write;
    logic             mem_read;
    logic             ir_write;
    logic             rr2sel;
    logic             wr_sel;
    logic             reg_write;
    logic             alusrc_a;
    logic             pc_src;
    logic             flag_write;
    logic             alu_op;
    logic [SEL_W-1:0] alusrc_b;
    logic [SEL_W-1:0] wd_sel;
    logic [ALU_W-1:0] alu_ctrl;
    logic             retire;
  } ctrl_t;

  function automatic logic inst_legal(input logic [INST_W-1:0] inst);
    return (inst == INST_DP) || (inst == INST_MEM) || (inst == INST_BR);
  endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// Combinational map from controller state and IR-derived fields to datapath controls.
module mc_output_decoder
  import multicycle_controller_pkg::*;
(
  input  state_t            state,
  input  logic [INST_W-1:0] inst,
  input  logic [ALU_W-1:0]  opc,
  input  logic              i,
  input  logic              l_br,
  input  logic              d,
  input  logic              e,
  output ctrl_t             ctrl
);

  logic skip;

  assign skip = !d || !inst_legal(inst);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = 1'b1;
        ctrl.pc_write = 1'b1;
      end
      S_DECODE: begin
        ctrl.rr2sel   = (inst != INST_MEM);
        ctrl.alusrc_b = ALUSRCB_OFFSET;
        ctrl.retire   = skip;
      end
      S_DP_EXEC: begin
        ctrl.alusrc_a   = 1'b1;
        ctrl.alusrc_b   = i ? ALUSRCB_OP2 : ALUSRCB_B;
        ctrl.alu_op     = 1'b1;
        ctrl.flag_write = 1'b1;
        ctrl.retire     = e;
      end
      S_DP_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.wd_sel    = WDSEL_ALUOUT;
        ctrl.retire    = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl.alusrc_a = 1'b1;
        ctrl.alusrc_b = ALUSRCB_OP2;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.wd_sel    = WDSEL_MDR;
        ctrl.retire    = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = 1'b1;
        ctrl.reg_write = l_br;
        ctrl.wr_sel    = 1'b1;
        ctrl.wd_sel    = WDSEL_PC;
        ctrl.retire    = 1'b1;
      end
      default: ;
    endcase
    // ALU runs the IR opcode only when the decoder hands it over; otherwise it adds.
    ctrl.alu_ctrl = ctrl.alu_op ? opc : ALU_ADD;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing controller: state register, next-state logic, output decoder.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] Inst,
  input  logic [2:0] OPC,
  input  logic       I,
  input  logic       L_tr,
  input  logic       L_br,
  input  logic       D,
  input  logic       E,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IRWrite,
  output logic       RR2sel,
  output logic       WRsel,
  output logic       RegWrite,
  output logic       ALUsrcA,
  output logic       PCsrc,
  output logic       flag_write,
  output logic       ALUop,
  output logic [1:0] ALUsrcB,
  output logic [1:0] WDsel,
  output logic [2:0] ALUctrl,
  output logic       retire
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   skip;

  assign skip = !D || !inst_legal(Inst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing; IR fields are stable from DECODE onward.
  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:     state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        if (skip)                  state_d = S_FETCH;
        else if (Inst == INST_DP)  state_d = S_DP_EXEC;
        else if (Inst == INST_MEM) state_d = S_MEM_ADDR;
        else                       state_d = S_BRANCH;
      end
      S_DP_EXEC:  state_d = E ? S_FETCH : S_DP_WB;
      S_MEM_ADDR: state_d = L_tr ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: state_d = S_MEM_WB;
      S_DP_WB,
      S_MEM_WB,
      S_MEM_WRITE,
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_INIT;
    endcase
  end

  mc_output_decoder u_dec (
    .state (state_q),
    .inst  (Inst),
    .opc   (OPC),
    .i     (I),
    .l_br  (L_br),
    .d     (D),
    .e     (E),
    .ctrl  (ctrl)
  );

  assign PCWrite    = ctrl.pc_write;
  assign IorD       = ctrl.iord;
  assign MemWrite   = ctrl.mem_write;
  assign MemRead    = ctrl.mem_read;
  assign IRWrite    = ctrl.ir_write;
  assign RR2sel     = ctrl.rr2sel;
  assign WRsel      = ctrl.wr_sel;
  assign RegWrite   = ctrl.reg_write;
  assign ALUsrcA    = ctrl.alusrc_a;
  assign PCsrc      = ctrl.pc_src;
  assign flag_write = ctrl.flag_write;
  assign ALUop      = ctrl.alu_op;
  assign ALUsrcB    = ctrl.alusrc_b;
  assign WDsel      = ctrl.wd_sel;
  assign ALUctrl    = ctrl.alu_ctrl;
  assign retire     = ctrl.retire;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle scripts derived from the instruction rules.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] Inst, OPC;
  logic       I, L_tr, L_br, D, E;
  logic       PCWrite, IorD, MemWrite, MemRead, IRWrite, RR2sel, WRsel, RegWrite;
  logic       ALUsrcA, PCsrc, flag_write, ALUop, retire;
  logic [1:0] ALUsrcB, WDsel;
  logic [2:0] ALUctrl;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic pcw, iord, mw, mr, irw, rr2, wrs, rw, asa, pcs, fw, aop;
    logic [1:0] asb;
    logic [1:0] wds;
    logic [2:0] actl;
    logic ret;
  } ev_t;

  typedef struct {
    logic [2:0] inst;
    logic [2:0] opc;
    logic i, l_tr, l_br, d, e;
  } instr_t;

  ev_t exp_q[$];

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Inst(Inst), .OPC(OPC), .I(I), .L_tr(L_tr), .L_br(L_br),
    .D(D), .E(E), .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .MemRead(MemRead),
    .IRWrite(IRWrite), .RR2sel(RR2sel), .WRsel(WRsel), .RegWrite(RegWrite),
    .ALUsrcA(ALUsrcA), .PCsrc(PCsrc), .flag_write(flag_write), .ALUop(ALUop),
    .ALUsrcB(ALUsrcB), .WDsel(WDsel), .ALUctrl(ALUctrl), .retire(retire)
  );

  always #5 clk = ~clk;

  function automatic ev_t outs();
    return {PCWrite, IorD, MemWrite, MemRead, IRWrite, RR2sel, WRsel, RegWrite,
            ALUsrcA, PCsrc, flag_write, ALUop, ALUsrcB, WDsel, ALUctrl, retire};
  endfunction

  function automatic instr_t mk_instr(input logic [2:0] inst, input logic [2:0] opc,
                                      input logic i, input logic l_tr, input logic l_br,
                                      input logic d, input logic e);
    instr_t t;
    t.inst = inst; t.opc = opc; t.i = i; t.l_tr = l_tr; t.l_br = l_br; t.d = d; t.e = e;
    return t;
  endfunction

  function automatic logic is_skip(input instr_t t);
    return !t.d || !(t.inst == 3'b000 || t.inst == 3'b010 || t.inst == 3'b101);
  endfunction

  // Cycle count from FETCH through the retiring cycle, by instruction kind.
  function automatic int lat_of(input instr_t t);
    if (is_skip(t))          return 2;
    if (t.inst == 3'b000)    return t.e ? 3 : 4;
    if (t.inst == 3'b101)    return 3;
    return t.l_tr ? 5 : 4;
  endfunction

  function automatic ev_t fetch_ev();
    ev_t v = '0;
    v.mr = 1'b1; v.irw = 1'b1; v.pcw = 1'b1;
    return v;
  endfunction

  // Expected control vector for every cycle of one instruction, FETCH first.
  function automatic void model(input instr_t t);
    ev_t v;
    exp_q.delete();
    exp_q.push_back(fetch_ev());
    v = '0; v.rr2 = (t.inst != 3'b010); v.asb = 2'b11; v.ret = is_skip(t);
    exp_q.push_back(v);
    if (is_skip(t)) return;
    if (t.inst == 3'b000) begin
      v = '0; v.asa = 1'b1; v.asb = t.i ? 2'b10 : 2'b01; v.aop = 1'b1; v.fw = 1'b1;
      v.actl = t.opc; v.ret = t.e;
      exp_q.push_back(v);
      if (!t.e) begin
        v = '0; v.rw = 1'b1; v.wds = 2'b10; v.ret = 1'b1;
        exp_q.push_back(v);
      end
    end else if (t.inst == 3'b010) begin
      v = '0; v.asa = 1'b1; v.asb = 2'b10;
      exp_q.push_back(v);
      if (t.l_tr) begin
        v = '0; v.mr = 1'b1; v.iord = 1'b1;
        exp_q.push_back(v);
        v = '0; v.rw = 1'b1; v.wds = 2'b00; v.ret = 1'b1;
        exp_q.push_back(v);
      end else begin
        v = '0; v.mw = 1'b1; v.iord = 1'b1; v.ret = 1'b1;
        exp_q.push_back(v);
      end
    end else begin
      v = '0; v.pcw = 1'b1; v.pcs = 1'b1; v.rw = t.l_br; v.wrs = 1'b1; v.wds = 2'b01; v.ret = 1'b1;
      exp_q.push_back(v);
    end
  endfunction

  task automatic drive(input instr_t t);
    Inst = t.inst; OPC = t.opc; I = t.i; L_tr = t.l_tr; L_br = t.l_br; D = t.d; E = t.e;
  endtask

  task automatic test_reset();
    ev_t o;
    rst_n = 1'b0;
    drive(mk_instr(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) begin
      @(negedge clk);
      total++; o = outs();
      if (o !== '0) begin bad++; $display("FAIL reset_hold got=%b want=0", o); end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++; o = outs();
    if (o !== '0) begin bad++; $display("FAIL reset_init got=%b want=0", o); end
    @(posedge clk); #1;
    total++; o = outs();
    if (o !== fetch_ev()) begin bad++; $display("FAIL reset_fetch got=%b want=%b", o, fetch_ev()); end
  endtask

  task automatic test_dp_reg();
    instr_t lst[2];
    ev_t o;
    int ret_at;
    lst[0] = mk_instr(3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    lst[1] = mk_instr(3'b000, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 2; n++) begin
      drive(lst[n]); model(lst[n]); ret_at = -1;
      foreach (exp_q[k]) begin
        @(negedge clk); total++; o = outs();
        if (o !== exp_q[k]) begin bad++; $display("FAIL dp_reg n=%0d cyc=%0d got=%b want=%b", n, k, o, exp_q[k]); end
        if (o.ret && ret_at < 0) ret_at = k;
        @(posedge clk); #1;
      end
      total++;
      if (ret_at + 1 != lat_of(lst[n])) begin bad++; $display("FAIL dp_reg_latency got=%0d want=%0d", ret_at + 1, lat_of(lst[n])); end
    end
  endtask

  task automatic test_compare();
    instr_t t;
    ev_t o;
    int rw_seen, ret_at;
    t = mk_instr(3'b000, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(t); model(t); rw_seen = 0; ret_at = -1;
    foreach (exp_q[k]) begin
      @(negedge clk); total++; o = outs();
      if (o !== exp_q[k]) begin bad++; $display("FAIL compare cyc=%0d got=%b want=%b", k, o, exp_q[k]); end
      if (o.rw) rw_seen++;
      if (o.ret && ret_at < 0) ret_at = k;
      @(posedge clk); #1;
    end
    total++;
    if (rw_seen != 0 || ret_at != 2) begin bad++; $display("FAIL compare_shape regwrites=%0d retire_cyc=%0d want 0 and 2", rw_seen, ret_at); end
  endtask

  task automatic test_load_store();
    instr_t lst[2];
    ev_t o;
    int mw_cnt, ret_at;
    lst[0] = mk_instr(3'b010, 3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    lst[1] = mk_instr(3'b010, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 2; n++) begin
      drive(lst[n]); model(lst[n]); mw_cnt = 0; ret_at = -1;
      foreach (exp_q[k]) begin
        @(negedge clk); total++; o = outs();
        if (o !== exp_q[k]) begin bad++; $display("FAIL load_store n=%0d cyc=%0d got=%b want=%b", n, k, o, exp_q[k]); end
        if (o.mw) mw_cnt++;
        if (o.ret && ret_at < 0) ret_at = k;
        @(posedge clk); #1;
      end
      total++;
      if (ret_at + 1 != lat_of(lst[n]) || mw_cnt != (lst[n].l_tr ? 0 : 1)) begin
        bad++; $display("FAIL load_store_shape n=%0d latency=%0d memwrites=%0d", n, ret_at + 1, mw_cnt);
      end
    end
  endtask

  task automatic test_branch();
    instr_t lst[2];
    ev_t o;
    lst[0] = mk_instr(3'b101, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    lst[1] = mk_instr(3'b101, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 2; n++) begin
      drive(lst[n]); model(lst[n]);
      foreach (exp_q[k]) begin
        @(negedge clk); total++; o = outs();
        if (o !== exp_q[k]) begin bad++; $display("FAIL branch n=%0d cyc=%0d got=%b want=%b", n, k, o, exp_q[k]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_skip();
    instr_t lst[3];
    ev_t o;
    lst[0] = mk_instr(3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lst[1] = mk_instr(3'b111, 3'b001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    lst[2] = mk_instr(3'b101, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      drive(lst[n]); model(lst[n]);
      foreach (exp_q[k]) begin
        @(negedge clk); total++; o = outs();
        if (o !== exp_q[k]) begin bad++; $display("FAIL skip n=%0d cyc=%0d got=%b want=%b", n, k, o, exp_q[k]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_abort();
    ev_t o;
    drive(mk_instr(3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (!(MemRead === 1'b1 && IorD === 1'b1)) begin bad++; $display("FAIL abort_pre got MemRead=%b IorD=%b want 1 1", MemRead, IorD); end
    rst_n = 1'b0; #1;
    total++; o = outs();
    if (o !== '0) begin bad++; $display("FAIL abort_immediate got=%b want=0", o); end
    @(posedge clk); #1;
    total++; o = outs();
    if (o !== '0) begin bad++; $display("FAIL abort_held got=%b want=0", o); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++; o = outs();
    if (o !== '0) begin bad++; $display("FAIL abort_no_wb got=%b want=0", o); end
    @(posedge clk); #1;
    total++; o = outs();
    if (o !== fetch_ev()) begin bad++; $display("FAIL abort_refetch got=%b want=%b", o, fetch_ev()); end
  endtask

  task automatic test_random();
    instr_t t;
    ev_t o;
    int ret_at;
    logic [2:0] legal[3];
    legal[0] = 3'b000; legal[1] = 3'b010; legal[2] = 3'b101;
    for (int n = 0; n < 60; n++) begin
      t.inst = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 2)];
      t.opc  = 3'($urandom_range(0, 7));
      t.i    = 1'($urandom_range(0, 1));
      t.l_tr = 1'($urandom_range(0, 1));
      t.l_br = 1'($urandom_range(0, 1));
      t.d    = ($urandom_range(0, 3) != 0);
      t.e    = 1'($urandom_range(0, 1));
      drive(t); model(t); ret_at = -1;
      foreach (exp_q[k]) begin
        @(negedge clk); total++; o = outs();
        if (o !== exp_q[k]) begin bad++; $display("FAIL random n=%0d cyc=%0d inst=%b got=%b want=%b", n, k, t.inst, o, exp_q[k]); end
        if ((o.mr && o.mw) || (o.pcw && o.rw && !o.pcs)) begin
          bad++; $display("FAIL random_exclusive n=%0d cyc=%0d got=%b", n, k, o);
        end
        if (o.ret && ret_at < 0) ret_at = k;
        @(posedge clk); #1;
      end
      total++;
      if (ret_at + 1 != lat_of(t)) begin bad++; $display("FAIL random_latency n=%0d got=%0d want=%0d", n, ret_at + 1, lat_of(t)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t o;
    test_reset();
    test_dp_reg();
    test_compare();
    test_load_store();
    test_branch();
    test_skip();
    test_abort();
    test_random();
    @(negedge clk); total++; o = outs();
    if (o !== fetch_ev()) begin bad++; $display("FAIL final_fetch got=%b want=%b", o, fetch_ev()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
